pipelined_barrel_shifter: RTL and testbench

Parametrised, fully pipelined barrel shifter for the execute stage of the processor. It supports logical left, logical right, arithmetic right and rotate right. The shift is split into log2(WIDTH) power-of-two levels (WIDTH/2, …, 2, 1), with one register stage per level. A valid/ready handshake provides backpressure, a synchronous flush supports branch recovery, and a tag (the destination register index) travels alongside each operation.

---
 rtl/pipelined_barrel_shifter_if.sv | 20 ++
 rtl/pipelined_barrel_shifter.sv | 76 +++++++
 tb/tb_pipelined_barrel_shifter.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_barrel_shifter_if.sv
// pipelined_barrel_shifter_if: operand/result handshake bundle of the pipelined barrel shifter
interface pipelined_barrel_shifter_if #(
  parameter int WIDTH = 32,
  parameter int SHAMT_W = 5,
  parameter int TAG_W = 5
);
  logic in_valid, in_ready, out_valid, out_ready;
  logic [WIDTH-1:0] data_input, data_output;
  logic [SHAMT_W-1:0] shamt;
  logic [1:0] op;
  logic [TAG_W-1:0] tag_in, tag_out;
  modport master (
    output in_valid, data_input, shamt, op, tag_in, out_ready,
    input in_ready, out_valid, data_output, tag_out
  );
  modport slave (
    input in_valid, data_input, shamt, op, tag_in, out_ready,
    output in_ready, out_valid, data_output, tag_out
  );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter: log2(WIDTH)-level SLL/SRL/SRA/ROR shifter, one register stage per level
module pipelined_barrel_shifter #(
  parameter int WIDTH = 32,
  parameter int SHAMT_W = 5,
  parameter int TAG_W = 5
) (
  input logic clock,
  input logic reset,
  input logic flush,
  pipelined_barrel_shifter_if.slave bus
);
  logic [WIDTH-1:0] d_q [SHAMT_W];
  logic [WIDTH-1:0] d_in [SHAMT_W];
  logic [WIDTH-1:0] d_nx [SHAMT_W];
  logic [SHAMT_W-1:0] s_q [SHAMT_W];
  logic [SHAMT_W-1:0] s_in [SHAMT_W];
  logic [1:0] op_q [SHAMT_W];
  logic [1:0] op_in [SHAMT_W];
  logic [TAG_W-1:0] t_q [SHAMT_W];
  logic [TAG_W-1:0] t_in [SHAMT_W];
  logic sg_q [SHAMT_W];
  logic sg_in [SHAMT_W];
  logic [SHAMT_W-1:0] v_q;
  logic stall;
  // The sign is latched at acceptance so SRA fill never depends on intermediate MSBs
  function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] x, input logic [1:0] o,
                                                input logic sg, input int s);
    logic [WIDTH-1:0] fill;
    fill = ~({WIDTH{1'b1}} >> s);
    return o == 2'd0 ? x << s :
           o == 2'd1 ? x >> s :
           o == 2'd2 ? (x >> s) | (sg ? fill : '0) : (x >> s) | (x << (WIDTH - s));
  endfunction
  assign stall = v_q[SHAMT_W-1] && !bus.out_ready;
  assign bus.in_ready = !stall;
  assign bus.out_valid = v_q[SHAMT_W-1];
  assign bus.data_output = d_q[SHAMT_W-1];
  assign bus.tag_out = t_q[SHAMT_W-1];
  always_comb begin
    d_in[0] = bus.data_input;
    s_in[0] = bus.shamt;
    op_in[0] = bus.op;
    t_in[0] = bus.tag_in;
    sg_in[0] = bus.data_input[WIDTH-1];
    for (int k = 1; k < SHAMT_W; k++) begin
      d_in[k] = d_q[k-1];
      s_in[k] = s_q[k-1];
      op_in[k] = op_q[k-1];
      t_in[k] = t_q[k-1];
      sg_in[k] = sg_q[k-1];
    end
    for (int k = 0; k < SHAMT_W; k++)
      d_nx[k] = s_in[k][SHAMT_W-1-k] ? shift_by(d_in[k], op_in[k], sg_in[k], WIDTH >> (k + 1)) : d_in[k];
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      v_q <= '0;
      for (int k = 0; k < SHAMT_W; k++) begin
        d_q[k] <= '0;
        s_q[k] <= '0;
        op_q[k] <= '0;
        t_q[k] <= '0;
        sg_q[k] <= 1'b0;
      end
    end else if (flush) v_q <= '0;
    else if (!stall) begin
      v_q <= {v_q[SHAMT_W-2:0], bus.in_valid};
      for (int k = 0; k < SHAMT_W; k++) begin
        d_q[k] <= d_nx[k];
        s_q[k] <= s_in[k];
        op_q[k] <= op_in[k];
        t_q[k] <= t_in[k];
        sg_q[k] <= sg_in[k];
      end
    end
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// tb_pipelined_barrel_shifter: directed and random checks of the shifter at WIDTH 32, 8 and 64
module tb_pipelined_barrel_shifter;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0;
  always #5 clk = ~clk;
  pipelined_barrel_shifter_if #(.WIDTH(32), .SHAMT_W(5), .TAG_W(5)) b32 ();
  pipelined_barrel_shifter_if #(.WIDTH(8), .SHAMT_W(3), .TAG_W(5)) b8 ();
  pipelined_barrel_shifter_if #(.WIDTH(64), .SHAMT_W(6), .TAG_W(5)) b64 ();
  pipelined_barrel_shifter #(.WIDTH(32), .SHAMT_W(5), .TAG_W(5)) u32 (.clock(clk), .reset(rst), .flush(flush), .bus(b32));
  pipelined_barrel_shifter #(.WIDTH(8), .SHAMT_W(3), .TAG_W(5)) u8 (.clock(clk), .reset(rst), .flush(flush), .bus(b8));
  pipelined_barrel_shifter #(.WIDTH(64), .SHAMT_W(6), .TAG_W(5)) u64 (.clock(clk), .reset(rst), .flush(flush), .bus(b64));
  typedef struct {
    logic [63:0] d;
    logic [7:0] t;
    int acc;
    int st;
  } ent_t;
  ent_t sb [3][$];
  int stalls [3];
  logic ps [3];
  logic [63:0] pd [3];
  logic [7:0] pt [3];
  logic [63:0] got [$];
  logic [7:0] gtag [$];
  logic acc0;
  int errors = 0, checks = 0, cyc = 0, n;
  logic [31:0] bd [8] = '{32'h1, 32'h1, 32'hF0000000, 32'hF0000000, 32'h12345678, 32'h12345678, 32'h7FFFFFFF, 32'h7FFFFFFF};
  int bs [8] = '{31, 0, 4, 0, 4, 0, 31, 0};
  int bo [8] = '{0, 0, 1, 1, 3, 3, 2, 2};
  logic [31:0] be [8] = '{32'h80000000, 32'h1, 32'h0F000000, 32'hF0000000, 32'h81234567, 32'h12345678, 32'h0, 32'h7FFFFFFF};
  // Bit-by-bit reference: each result bit names the source bit it comes from
  function automatic logic [63:0] model(logic [63:0] x, int s, logic [1:0] o, int w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < w; i++) begin
      int j;
      j = i + s;
      case (o)
        2'd0: r[i] = (i >= s) ? x[i - s] : 1'b0;
        2'd1: r[i] = (j < w) ? x[j] : 1'b0;
        2'd2: r[i] = (j < w) ? x[j] : x[w - 1];
        default: r[i] = x[j % w];
      endcase
    end
    return r;
  endfunction
  task automatic chk(string name, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", name, obs, exp);
    end
  endtask
  task automatic hs(int i, int w, int lat, logic iv, logic ir, logic [63:0] din, int sh, logic [1:0] o,
                    logic [7:0] tg, logic ov, logic orr, logic [63:0] dout, logic [7:0] tout);
    ent_t e;
    string nm;
    nm = $sformatf("w%0d", w);
    chk({nm, " in_ready"}, 64'(ir), 64'(!(ov && !orr)));
    if (ps[i]) begin
      chk({nm, " hold_data"}, dout, pd[i]);
      chk({nm, " hold_tag"}, 64'(tout), 64'(pt[i]));
    end
    ps[i] = ov && !orr && !flush;
    pd[i] = dout;
    pt[i] = tout;
    if (i == 0) acc0 = iv && ir && !flush;
    if (flush) sb[i].delete();
    else begin
      if (ov && orr) begin
        chk({nm, " out_expected"}, 64'(sb[i].size() != 0), 64'd1);
        if (sb[i].size() != 0) begin
          e = sb[i].pop_front();
          chk({nm, " data"}, dout, e.d);
          chk({nm, " tag"}, 64'(tout), 64'(e.t));
          chk({nm, " latency"}, 64'(cyc - e.acc - (stalls[i] - e.st)), 64'(lat));
          if (i == 0) begin
            got.push_back(dout);
            gtag.push_back(tout);
          end
        end
      end
      if (ov && !orr) stalls[i]++;
      if (iv && ir) sb[i].push_back('{model(din, sh, o, w), tg, cyc, stalls[i]});
    end
  endtask
  task automatic tick();
    #1;
    hs(0, 32, 5, b32.in_valid, b32.in_ready, 64'(b32.data_input), int'(b32.shamt), b32.op, 8'(b32.tag_in),
       b32.out_valid, b32.out_ready, 64'(b32.data_output), 8'(b32.tag_out));
    hs(1, 8, 3, b8.in_valid, b8.in_ready, 64'(b8.data_input), int'(b8.shamt), b8.op, 8'(b8.tag_in),
       b8.out_valid, b8.out_ready, 64'(b8.data_output), 8'(b8.tag_out));
    hs(2, 64, 6, b64.in_valid, b64.in_ready, b64.data_input, int'(b64.shamt), b64.op, 8'(b64.tag_in),
       b64.out_valid, b64.out_ready, b64.data_output, 8'(b64.tag_out));
    @(posedge clk);
    cyc++;
    #1;
  endtask
  task automatic sb_clear();
    for (int i = 0; i < 3; i++) begin
      sb[i].delete();
      ps[i] = 1'b0;
    end
  endtask
  task automatic idle();
    flush = 1'b0;
    b32.in_valid = 1'b0; b32.data_input = '0; b32.shamt = '0; b32.op = '0; b32.tag_in = '0; b32.out_ready = 1'b1;
    b8.in_valid = 1'b0; b8.data_input = '0; b8.shamt = '0; b8.op = '0; b8.tag_in = '0; b8.out_ready = 1'b1;
    b64.in_valid = 1'b0; b64.data_input = '0; b64.shamt = '0; b64.op = '0; b64.tag_in = '0; b64.out_ready = 1'b1;
  endtask
  task automatic put(logic v, logic [31:0] d, int s, int o, int t);
    b32.in_valid = v; b32.data_input = d; b32.shamt = 5'(s); b32.op = 2'(o); b32.tag_in = 5'(t);
  endtask
  task automatic rnd();
    flush = $urandom_range(0, 39) == 0;
    b32.in_valid = 1'($urandom); b32.data_input = $urandom; b32.shamt = 5'($urandom);
    b32.op = 2'($urandom); b32.tag_in = 5'($urandom); b32.out_ready = $urandom_range(0, 3) != 0;
    b8.in_valid = 1'($urandom); b8.data_input = 8'($urandom); b8.shamt = 3'($urandom);
    b8.op = 2'($urandom); b8.tag_in = 5'($urandom); b8.out_ready = $urandom_range(0, 3) != 0;
    b64.in_valid = 1'($urandom); b64.data_input = {$urandom, $urandom}; b64.shamt = 6'($urandom);
    b64.op = 2'($urandom); b64.tag_in = 5'($urandom); b64.out_ready = $urandom_range(0, 3) != 0;
  endtask
  initial begin
    idle();
    sb_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", 64'(b32.out_valid), 0);
    chk("reset data_output", 64'(b32.data_output), 0);
    chk("reset tag_out", 64'(b32.tag_out), 0);
    rst = 1'b0;
    #1;
    chk("reset in_ready", 64'(b32.in_ready), 1);
    put(1, 32'h80000000, 8, 2, 3);
    tick();
    chk("sra accepted", 64'(acc0), 1);
    idle();
    repeat (3) tick();
    chk("sra early", 64'(b32.out_valid), 0);
    tick();
    chk("sra out_valid", 64'(b32.out_valid), 1);
    chk("sra data", 64'(b32.data_output), 64'h00000000FF800000);
    chk("sra tag", 64'(b32.tag_out), 3);
    tick();
    chk("sra one cycle", 64'(b32.out_valid), 0);
    got.delete();
    for (int k = 0; k < 8; k++) begin
      put(1, bd[k], bs[k], bo[k], k);
      tick();
    end
    idle();
    repeat (6) tick();
    chk("b2b count", 64'(got.size()), 8);
    for (int k = 0; k < 8 && k < got.size(); k++) chk($sformatf("b2b result %0d", k), got[k], 64'(be[k]));
    got.delete();
    gtag.delete();
    n = 0;
    for (int c = 0; c < 26; c++) begin
      if (n < 8) put(1, $urandom, $urandom_range(0, 31), $urandom_range(0, 3), n);
      else b32.in_valid = 1'b0;
      b32.out_ready = !(c >= 6 && c <= 12);
      tick();
      if (acc0) n++;
    end
    chk("bp accepted", 64'(n), 8);
    chk("bp count", 64'(gtag.size()), 8);
    for (int k = 0; k < 8 && k < gtag.size(); k++) chk($sformatf("bp order %0d", k), 64'(gtag[k]), 64'(k));
    idle();
    for (int k = 0; k < 3; k++) begin
      put(1, 32'hFFFF0000 + k, 3, k, k + 1);
      tick();
    end
    put(1, 32'h0000DEAD, 1, 0, 4);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush out_valid", 64'(b32.out_valid), 0);
    got.delete();
    put(1, 32'h1, 4, 0, 9);
    tick();
    idle();
    repeat (3) tick();
    chk("post flush early", 64'(b32.out_valid), 0);
    tick();
    chk("post flush valid", 64'(b32.out_valid), 1);
    chk("post flush data", 64'(b32.data_output), 64'h10);
    chk("post flush tag", 64'(b32.tag_out), 9);
    repeat (5) tick();
    chk("post flush count", 64'(got.size()), 1);
    for (int k = 0; k < 4; k++) begin
      put(1, 32'hA5A50000 | k, 1, 0, k + 10);
      b32.out_ready = 1'b0;
      tick();
    end
    idle();
    b32.out_ready = 1'b0;
    repeat (3) tick();
    chk("stalled out_valid", 64'(b32.out_valid), 1);
    #3;
    rst = 1'b1;
    #1;
    chk("async out_valid", 64'(b32.out_valid), 0);
    chk("async data_output", 64'(b32.data_output), 0);
    chk("async tag_out", 64'(b32.tag_out), 0);
    sb_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("post reset in_ready", 64'(b32.in_ready), 1);
    b32.out_ready = 1'b1;
    got.delete();
    put(1, 32'hF0, 4, 1, 21);
    tick();
    idle();
    repeat (6) tick();
    chk("post reset count", 64'(got.size()), 1);
    if (got.size() != 0) chk("post reset data", got[0], 64'h0F);
    repeat (400) begin
      rnd();
      tick();
    end
    idle();
    repeat (10) tick();
    chk("drain w32", 64'(sb[0].size()), 0);
    chk("drain w8", 64'(sb[1].size()), 0);
    chk("drain w64", 64'(sb[2].size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
